// File: rtl/simd_alu_pipe_if.sv
// Beat-level bus of simd_alu_pipe: input beat, result beat and status.
// Handshake: a beat transfers on a rising edge where valid && ready; ready never waits on valid.
interface simd_alu_pipe_if #(
    parameter int LANES         = 4,
    parameter int OPERAND_WIDTH = 32
);
    logic                             i_valid;
    logic                             o_ready;
    logic [1:0]                       opcode;
    logic [LANES*OPERAND_WIDTH-1:0]   i_in1;
    logic [LANES*OPERAND_WIDTH-1:0]   i_in2;
    logic [LANES-1:0]                 i_mask;
    logic                             i_acc_clr;
    logic                             o_valid;
    logic                             i_ready;
    logic [LANES*OPERAND_WIDTH-1:0]   o_res;
    logic                             o_busy;

    modport master (
        output i_valid, opcode, i_in1, i_in2, i_mask, i_acc_clr, i_ready,
        input  o_ready, o_valid, o_res, o_busy
    );

    modport slave (
        input  i_valid, opcode, i_in1, i_in2, i_mask, i_acc_clr, i_ready,
        output o_ready, o_valid, o_res, o_busy
    );
endinterface

// File: rtl/simd_alu_pipe.sv
// Pipelined SIMD ALU: per-lane ADD/MUL/SUB/MAC with fixed latency MUL_STAGES+1.
// Define SIMD_ALU_SAT_EN for signed saturating ADD, SUB and MAC accumulate.
module simd_alu_pipe #(
    parameter int LANES         = 4,
    parameter int OPERAND_WIDTH = 32,
    parameter int MUL_STAGES    = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    simd_alu_pipe_if.slave       bus
);
    localparam int OW = OPERAND_WIDTH;
    localparam int VW = LANES * OW;
    localparam int NS = MUL_STAGES;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_MUL = 2'b01,
        OP_SUB = 2'b10,
        OP_MAC = 2'b11
    } op_e;

`ifdef SIMD_ALU_SAT_EN
    function automatic logic [OW-1:0] lane_add(input logic [OW-1:0] a, input logic [OW-1:0] b);
        logic [OW:0] s;
        s = {a[OW-1], a} + {b[OW-1], b};
        if (s[OW] != s[OW-1])
            return s[OW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        return s[OW-1:0];
    endfunction

    function automatic logic [OW-1:0] lane_sub(input logic [OW-1:0] a, input logic [OW-1:0] b);
        logic [OW:0] s;
        s = {a[OW-1], a} - {b[OW-1], b};
        if (s[OW] != s[OW-1])
            return s[OW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        return s[OW-1:0];
    endfunction
`else
    function automatic logic [OW-1:0] lane_add(input logic [OW-1:0] a, input logic [OW-1:0] b);
        return a + b;
    endfunction

    function automatic logic [OW-1:0] lane_sub(input logic [OW-1:0] a, input logic [OW-1:0] b);
        return a - b;
    endfunction
`endif

    function automatic logic [OW-1:0] lane_mul(input logic [OW-1:0] a, input logic [OW-1:0] b);
        return a * b;
    endfunction

    logic [NS-1:0]             stg_valid_q, stg_valid_d;
    logic [NS-1:0][1:0]        stg_op_q,    stg_op_d;
    logic [NS-1:0][LANES-1:0]  stg_mask_q,  stg_mask_d;
    logic [NS-1:0][VW-1:0]     stg_data_q,  stg_data_d;
    logic                      out_valid_q, out_valid_d;
    logic [VW-1:0]             out_res_q,   out_res_d;
    logic [VW-1:0]             acc_q,       acc_d;

    logic                      advance;
    logic                      in_fire;
    logic [VW-1:0]             in_data;
    logic [VW-1:0]             acc_base;

    assign advance     = !out_valid_q || bus.i_ready;
    assign in_fire     = bus.i_valid && advance;
    assign bus.o_ready = advance;
    assign bus.o_valid = out_valid_q;
    assign bus.o_res   = out_res_q;
    assign bus.o_busy  = (|stg_valid_q) || out_valid_q;

    // The product is formed at entry and carried through NS registers so
    // synthesis retiming can spread the multiplier across them.
    always_comb begin
        in_data = '0;
        for (int k = 0; k < LANES; k++) begin
            case (bus.opcode)
                OP_ADD:  in_data[k*OW +: OW] = lane_add(bus.i_in1[k*OW +: OW], bus.i_in2[k*OW +: OW]);
                OP_SUB:  in_data[k*OW +: OW] = lane_sub(bus.i_in1[k*OW +: OW], bus.i_in2[k*OW +: OW]);
                default: in_data[k*OW +: OW] = lane_mul(bus.i_in1[k*OW +: OW], bus.i_in2[k*OW +: OW]);
            endcase
        end
    end

    always_comb begin
        stg_valid_d = stg_valid_q;
        stg_op_d    = stg_op_q;
        stg_mask_d  = stg_mask_q;
        stg_data_d  = stg_data_q;
        if (advance) begin
            stg_valid_d[0] = in_fire;
            stg_op_d[0]    = bus.opcode;
            stg_mask_d[0]  = bus.i_mask;
            stg_data_d[0]  = in_data;
            for (int i = 1; i < NS; i++) begin
                stg_valid_d[i] = stg_valid_q[i-1];
                stg_op_d[i]    = stg_op_q[i-1];
                stg_mask_d[i]  = stg_mask_q[i-1];
                stg_data_d[i]  = stg_data_q[i-1];
            end
        end
    end

    // Clear is applied before any MAC landing on the same edge, even while stalled.
    always_comb begin
        acc_base    = bus.i_acc_clr ? '0 : acc_q;
        acc_d       = acc_base;
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        if (advance) begin
            out_valid_d = stg_valid_q[NS-1];
            if (stg_valid_q[NS-1]) begin
                for (int k = 0; k < LANES; k++) begin
                    if (!stg_mask_q[NS-1][k]) begin
                        out_res_d[k*OW +: OW] = '0;
                    end else if (stg_op_q[NS-1] == OP_MAC) begin
                        acc_d[k*OW +: OW]     = lane_add(acc_base[k*OW +: OW], stg_data_q[NS-1][k*OW +: OW]);
                        out_res_d[k*OW +: OW] = acc_d[k*OW +: OW];
                    end else begin
                        out_res_d[k*OW +: OW] = stg_data_q[NS-1][k*OW +: OW];
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stg_valid_q <= '0;
            stg_op_q    <= '0;
            stg_mask_q  <= '0;
            stg_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            acc_q       <= '0;
        end else begin
            stg_valid_q <= stg_valid_d;
            stg_op_q    <= stg_op_d;
            stg_mask_q  <= stg_mask_d;
            stg_data_q  <= stg_data_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            acc_q       <= acc_d;
        end
    end
endmodule
